decode_queue: RTL

- Buffered, pipelined RV32 decode stage between instruction fetch and execute.
- Accepts fetched instruction/PC pairs over a valid/ready handshake and holds them in a DEPTH-entry queue.
- Decodes the head entry into Bundle::ControlSignals and presents the result from a registered output stage.
- Adds a parametrised queue, optional M-extension decode, illegal-instruction flagging and pipeline flush.

---
 rtl/decode_queue_pkg.sv | 43 ++++
 rtl/decode_queue_decode_table.sv | 190 +++++++++++++++++++
 rtl/decode_queue.sv | 121 ++++++++++++
 3 files changed

// File: rtl/decode_queue_pkg.sv
// Shared decode types: ALU/immediate/memory/CSR selector enums, the ControlSignals
// bundle handed to execute, and the all-inactive default bundle.
package decode_queue_pkg;

  typedef enum logic [2:0] {A2_X, A2_ZERO, A2_SIZE, A2_RS2, A2_IMM} sel_alu2_e;
  typedef enum logic [1:0] {A1_X, A1_ZERO, A1_RS1, A1_PC} sel_alu1_e;
  typedef enum logic [2:0] {IMM_X, IMM_S, IMM_SB, IMM_U, IMM_UJ, IMM_I, IMM_Z} sel_imm_e;

  typedef enum logic [4:0] {
    FN_ADD, FN_SL, FN_SEQ, FN_SNE, FN_XOR, FN_SR, FN_OR, FN_AND,
    FN_SUB, FN_SRA, FN_SLT, FN_SGE, FN_SLTU, FN_SGEU,
    FN_MUL, FN_MULH, FN_MULHSU, FN_MULHU, FN_DIV, FN_DIVU, FN_REM, FN_REMU
  } alu_fn_e;

  typedef enum logic [1:0] {M_X, M_XRD, M_XWR} mem_cmd_e;
  typedef enum logic [2:0] {MT_X, MT_B, MT_H, MT_W, MT_BU, MT_HU} mem_type_e;
  typedef enum logic [2:0] {CSR_N, CSR_W, CSR_S, CSR_C, CSR_I} csr_e;

  typedef struct packed {
    logic      legal;
    logic      branch;
    logic      jal;
    logic      jalr;
    logic      rxs2;
    logic      rxs1;
    sel_alu2_e sel_alu2;
    sel_alu1_e sel_alu1;
    sel_imm_e  sel_imm;
    alu_fn_e   alu_fun;
    logic      mem;
    mem_cmd_e  mem_cmd;
    mem_type_e mem_type;
    logic      wxd;
    csr_e      csr;
    logic      fence_i;
    logic      fence;
    logic      div;
  } ControlSignals;

  // Every selector's first enumerator is its "don't care", so all-zero is inactive and illegal.
  localparam ControlSignals cs_default = '0;

endpackage

// File: rtl/decode_queue_decode_table.sv
// Combinational RV32I (+ optional M, optional Zicsr) decode of one instruction word
// into a ControlSignals bundle; unmatched or disabled encodings return cs_default.
`ifndef DECODE_QUEUE_INSTRUCTIONS
`define DECODE_QUEUE_INSTRUCTIONS
`define RV_LUI     32'b???????_?????_?????_???_?????_0110111
`define RV_AUIPC   32'b???????_?????_?????_???_?????_0010111
`define RV_JAL     32'b???????_?????_?????_???_?????_1101111
`define RV_JALR    32'b???????_?????_?????_000_?????_1100111
`define RV_BEQ     32'b???????_?????_?????_000_?????_1100011
`define RV_BNE     32'b???????_?????_?????_001_?????_1100011
`define RV_BLT     32'b???????_?????_?????_100_?????_1100011
`define RV_BGE     32'b???????_?????_?????_101_?????_1100011
`define RV_BLTU    32'b???????_?????_?????_110_?????_1100011
`define RV_BGEU    32'b???????_?????_?????_111_?????_1100011
`define RV_LB      32'b???????_?????_?????_000_?????_0000011
`define RV_LH      32'b???????_?????_?????_001_?????_0000011
`define RV_LW      32'b???????_?????_?????_010_?????_0000011
`define RV_LBU     32'b???????_?????_?????_100_?????_0000011
`define RV_LHU     32'b???????_?????_?????_101_?????_0000011
`define RV_SB      32'b???????_?????_?????_000_?????_0100011
`define RV_SH      32'b???????_?????_?????_001_?????_0100011
`define RV_SW      32'b???????_?????_?????_010_?????_0100011
`define RV_ADDI    32'b???????_?????_?????_000_?????_0010011
`define RV_SLTI    32'b???????_?????_?????_010_?????_0010011
`define RV_SLTIU   32'b???????_?????_?????_011_?????_0010011
`define RV_XORI    32'b???????_?????_?????_100_?????_0010011
`define RV_ORI     32'b???????_?????_?????_110_?????_0010011
`define RV_ANDI    32'b???????_?????_?????_111_?????_0010011
`define RV_SLLI    32'b0000000_?????_?????_001_?????_0010011
`define RV_SRLI    32'b0000000_?????_?????_101_?????_0010011
`define RV_SRAI    32'b0100000_?????_?????_101_?????_0010011
`define RV_ADD     32'b0000000_?????_?????_000_?????_0110011
`define RV_SUB     32'b0100000_?????_?????_000_?????_0110011
`define RV_SLL     32'b0000000_?????_?????_001_?????_0110011
`define RV_SLT     32'b0000000_?????_?????_010_?????_0110011
`define RV_SLTU    32'b0000000_?????_?????_011_?????_0110011
`define RV_XOR     32'b0000000_?????_?????_100_?????_0110011
`define RV_SRL     32'b0000000_?????_?????_101_?????_0110011
`define RV_SRA     32'b0100000_?????_?????_101_?????_0110011
`define RV_OR      32'b0000000_?????_?????_110_?????_0110011
`define RV_AND     32'b0000000_?????_?????_111_?????_0110011
`define RV_FENCE   32'b???????_?????_?????_000_?????_0001111
`define RV_FENCE_I 32'b???????_?????_?????_001_?????_0001111
`define RV_ECALL   32'b0000000_00000_00000_000_00000_1110011
`define RV_EBREAK  32'b0000000_00001_00000_000_00000_1110011
`define RV_CSRRW   32'b???????_?????_?????_001_?????_1110011
`define RV_CSRRS   32'b???????_?????_?????_010_?????_1110011
`define RV_CSRRC   32'b???????_?????_?????_011_?????_1110011
`define RV_CSRRWI  32'b???????_?????_?????_101_?????_1110011
`define RV_CSRRSI  32'b???????_?????_?????_110_?????_1110011
`define RV_CSRRCI  32'b???????_?????_?????_111_?????_1110011
`define RV_MUL     32'b0000001_?????_?????_000_?????_0110011
`define RV_MULH    32'b0000001_?????_?????_001_?????_0110011
`define RV_MULHSU  32'b0000001_?????_?????_010_?????_0110011
`define RV_MULHU   32'b0000001_?????_?????_011_?????_0110011
`define RV_DIV     32'b0000001_?????_?????_100_?????_0110011
`define RV_DIVU    32'b0000001_?????_?????_101_?????_0110011
`define RV_REM     32'b0000001_?????_?????_110_?????_0110011
`define RV_REMU    32'b0000001_?????_?????_111_?????_0110011
`endif

module rv_decode_table
  import decode_queue_pkg::*;
#(
  parameter bit USE_M   = 1'b0,
  parameter bit USE_CSR = 1'b1
) (
  input  logic [31:0]   instruction,
  output ControlSignals cs
);

  function automatic ControlSignals rr_op(input alu_fn_e fn, input logic is_md);
    ControlSignals c;
    c = cs_default;
    c.legal = 1'b1; c.rxs2 = 1'b1; c.rxs1 = 1'b1;
    c.sel_alu2 = A2_RS2; c.sel_alu1 = A1_RS1; c.alu_fun = fn;
    c.wxd = 1'b1; c.div = is_md;
    return c;
  endfunction

  function automatic ControlSignals ri_op(input alu_fn_e fn);
    ControlSignals c;
    c = cs_default;
    c.legal = 1'b1; c.rxs1 = 1'b1;
    c.sel_alu2 = A2_IMM; c.sel_alu1 = A1_RS1; c.sel_imm = IMM_I; c.alu_fun = fn;
    c.wxd = 1'b1;
    return c;
  endfunction

  function automatic ControlSignals br_op(input alu_fn_e fn);
    ControlSignals c;
    c = cs_default;
    c.legal = 1'b1; c.branch = 1'b1; c.rxs2 = 1'b1; c.rxs1 = 1'b1;
    c.sel_alu2 = A2_RS2; c.sel_alu1 = A1_RS1; c.sel_imm = IMM_SB; c.alu_fun = fn;
    return c;
  endfunction

  function automatic ControlSignals mem_op(input logic is_store, input mem_type_e mt);
    ControlSignals c;
    c = cs_default;
    c.legal = 1'b1; c.rxs1 = 1'b1; c.rxs2 = is_store;
    c.sel_alu2 = A2_IMM; c.sel_alu1 = A1_RS1; c.alu_fun = FN_ADD;
    c.mem = 1'b1; c.mem_type = mt;
    if (is_store) begin
      c.sel_imm = IMM_S; c.mem_cmd = M_XWR;
    end else begin
      c.sel_imm = IMM_I; c.mem_cmd = M_XRD; c.wxd = 1'b1;
    end
    return c;
  endfunction

  // Immediate CSR forms take the zero-extended rs1 field as the operand, not rs1 itself.
  function automatic ControlSignals csr_op(input csr_e op, input logic use_imm);
    ControlSignals c;
    c = cs_default;
    c.legal = 1'b1; c.alu_fun = FN_ADD; c.wxd = 1'b1; c.csr = op;
    if (use_imm) begin
      c.sel_alu2 = A2_IMM; c.sel_alu1 = A1_ZERO; c.sel_imm = IMM_Z;
    end else begin
      c.rxs1 = 1'b1; c.sel_alu2 = A2_ZERO; c.sel_alu1 = A1_RS1; c.sel_imm = IMM_I;
    end
    return c;
  endfunction

  always_comb begin
    cs = cs_default;
    case (instruction) inside
      `RV_LUI:     begin cs = ri_op(FN_ADD); cs.rxs1 = 1'b0; cs.sel_alu1 = A1_ZERO; cs.sel_imm = IMM_U; end
      `RV_AUIPC:   begin cs = ri_op(FN_ADD); cs.rxs1 = 1'b0; cs.sel_alu1 = A1_PC;   cs.sel_imm = IMM_U; end
      `RV_JAL:     begin
        cs = ri_op(FN_ADD); cs.jal = 1'b1; cs.rxs1 = 1'b0;
        cs.sel_alu2 = A2_SIZE; cs.sel_alu1 = A1_PC; cs.sel_imm = IMM_UJ;
      end
      `RV_JALR:    begin cs = ri_op(FN_ADD); cs.jalr = 1'b1; end
      `RV_BEQ:     cs = br_op(FN_SEQ);
      `RV_BNE:     cs = br_op(FN_SNE);
      `RV_BLT:     cs = br_op(FN_SLT);
      `RV_BGE:     cs = br_op(FN_SGE);
      `RV_BLTU:    cs = br_op(FN_SLTU);
      `RV_BGEU:    cs = br_op(FN_SGEU);
      `RV_LB:      cs = mem_op(1'b0, MT_B);
      `RV_LH:      cs = mem_op(1'b0, MT_H);
      `RV_LW:      cs = mem_op(1'b0, MT_W);
      `RV_LBU:     cs = mem_op(1'b0, MT_BU);
      `RV_LHU:     cs = mem_op(1'b0, MT_HU);
      `RV_SB:      cs = mem_op(1'b1, MT_B);
      `RV_SH:      cs = mem_op(1'b1, MT_H);
      `RV_SW:      cs = mem_op(1'b1, MT_W);
      `RV_ADDI:    cs = ri_op(FN_ADD);
      `RV_SLTI:    cs = ri_op(FN_SLT);
      `RV_SLTIU:   cs = ri_op(FN_SLTU);
      `RV_XORI:    cs = ri_op(FN_XOR);
      `RV_ORI:     cs = ri_op(FN_OR);
      `RV_ANDI:    cs = ri_op(FN_AND);
      `RV_SLLI:    cs = ri_op(FN_SL);
      `RV_SRLI:    cs = ri_op(FN_SR);
      `RV_SRAI:    cs = ri_op(FN_SRA);
      `RV_ADD:     cs = rr_op(FN_ADD,  1'b0);
      `RV_SUB:     cs = rr_op(FN_SUB,  1'b0);
      `RV_SLL:     cs = rr_op(FN_SL,   1'b0);
      `RV_SLT:     cs = rr_op(FN_SLT,  1'b0);
      `RV_SLTU:    cs = rr_op(FN_SLTU, 1'b0);
      `RV_XOR:     cs = rr_op(FN_XOR,  1'b0);
      `RV_SRL:     cs = rr_op(FN_SR,   1'b0);
      `RV_SRA:     cs = rr_op(FN_SRA,  1'b0);
      `RV_OR:      cs = rr_op(FN_OR,   1'b0);
      `RV_AND:     cs = rr_op(FN_AND,  1'b0);
      `RV_FENCE:   begin cs.legal = 1'b1; cs.fence   = 1'b1; end
      `RV_FENCE_I: begin cs.legal = 1'b1; cs.fence_i = 1'b1; end
      `RV_ECALL:   begin cs.legal = 1'b1; cs.csr = CSR_I; end
      `RV_EBREAK:  begin cs.legal = 1'b1; cs.csr = CSR_I; end
      `RV_CSRRW:   if (USE_CSR) cs = csr_op(CSR_W, 1'b0);
      `RV_CSRRS:   if (USE_CSR) cs = csr_op(CSR_S, 1'b0);
      `RV_CSRRC:   if (USE_CSR) cs = csr_op(CSR_C, 1'b0);
      `RV_CSRRWI:  if (USE_CSR) cs = csr_op(CSR_W, 1'b1);
      `RV_CSRRSI:  if (USE_CSR) cs = csr_op(CSR_S, 1'b1);
      `RV_CSRRCI:  if (USE_CSR) cs = csr_op(CSR_C, 1'b1);
      `RV_MUL:     if (USE_M) cs = rr_op(FN_MUL,    1'b1);
      `RV_MULH:    if (USE_M) cs = rr_op(FN_MULH,   1'b1);
      `RV_MULHSU:  if (USE_M) cs = rr_op(FN_MULHSU, 1'b1);
      `RV_MULHU:   if (USE_M) cs = rr_op(FN_MULHU,  1'b1);
      `RV_DIV:     if (USE_M) cs = rr_op(FN_DIV,    1'b1);
      `RV_DIVU:    if (USE_M) cs = rr_op(FN_DIVU,   1'b1);
      `RV_REM:     if (USE_M) cs = rr_op(FN_REM,    1'b1);
      `RV_REMU:    if (USE_M) cs = rr_op(FN_REMU,   1'b1);
      default:     cs = cs_default;
    endcase
  end

endmodule

// File: rtl/decode_queue.sv
// Fetch-to-execute decode stage: DEPTH-entry instruction queue feeding a registered
// output stage that carries the decoded ControlSignals of the queue head.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned XLEN    = 32,
  parameter bit          USE_M   = 1'b0,
  parameter bit          USE_CSR = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     if_valid,
  output logic                     if_ready,
  input  logic [31:0]              if_instruction,
  input  logic [XLEN-1:0]          if_pc,
  input  logic                     flush,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [31:0]              id_instruction,
  output logic [XLEN-1:0]          id_pc,
  output ControlSignals            id_cs,
  output logic                     id_illegal,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [31:0]     ins_mem [DEPTH];
  logic [XLEN-1:0] pc_mem  [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             id_valid_q, id_valid_d, id_ill_q, id_ill_d;
  logic [31:0]      id_ins_q, id_ins_d;
  logic [XLEN-1:0]  id_pc_q, id_pc_d;
  ControlSignals    id_cs_q, id_cs_d, head_cs;
  logic             enq, deq, load;

  rv_decode_table #(
    .USE_M   (USE_M),
    .USE_CSR (USE_CSR)
  ) u_decode (
    .instruction (ins_mem[rd_ptr_q]),
    .cs          (head_cs)
  );

  // Readiness comes only from registered occupancy, so execute back-pressure never reaches fetch combinationally.
  assign if_ready = (occ_q != OCC_W'(DEPTH));
  assign load     = !id_valid_q || id_ready;
  assign enq      = if_valid && if_ready && !flush;
  assign deq      = load && (occ_q != '0) && !flush;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    occ_d      = occ_q;
    id_valid_d = id_valid_q;
    id_ins_d   = id_ins_q;
    id_pc_d    = id_pc_q;
    id_cs_d    = id_cs_q;
    id_ill_d   = id_ill_q;
    if (flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      occ_d      = '0;
      id_valid_d = 1'b0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      occ_d = occ_q + OCC_W'(enq) - OCC_W'(deq);
      if (load) begin
        id_valid_d = deq;
        if (deq) begin
          id_ins_d = ins_mem[rd_ptr_q];
          id_pc_d  = pc_mem[rd_ptr_q];
          id_cs_d  = head_cs;
          id_ill_d = !head_cs.legal;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      ins_mem[wr_ptr_q] <= if_instruction;
      pc_mem[wr_ptr_q]  <= if_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= '0;
      id_valid_q <= 1'b0;
      id_ins_q   <= '0;
      id_pc_q    <= '0;
      id_cs_q    <= cs_default;
      id_ill_q   <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
      id_valid_q <= id_valid_d;
      id_ins_q   <= id_ins_d;
      id_pc_q    <= id_pc_d;
      id_cs_q    <= id_cs_d;
      id_ill_q   <= id_ill_d;
    end
  end

  assign id_valid       = id_valid_q;
  assign id_instruction = id_ins_q;
  assign id_pc          = id_pc_q;
  assign id_cs          = id_cs_q;
  assign id_illegal     = id_ill_q;
  assign occupancy      = occ_q;

endmodule
